// File: rtl/spi_master.sv
// Single-byte SPI mode-0 master (CPOL=0, CPHA=0), MSB first, full duplex.
// sclk half-period is CLK_DIV system clocks. A byte may keep ss low afterwards so a
// following byte continues the burst without deselecting the slave.
module spi_master #(
  parameter int unsigned CLK_DIV = 4  // sclk half-period in clk cycles, 2..255
) (
  input  logic       clk,
  input  logic       rst_L,
  input  logic       start,
  input  logic [7:0] tx_data,
  input  logic       hold_ss,
  output logic       busy,
  output logic       done,
  output logic [7:0] rx_data,
  output logic       sclk,
  output logic       ss,
  output logic       mosi,
  input  logic       miso
);

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StHigh,
    StLow,
    StFinish,
    StDesel
  } state_e;

  localparam logic [7:0] DivLast = 8'(CLK_DIV - 1);

  state_e     state_q, state_d;
  logic [7:0] div_q, div_d;
  logic [2:0] bit_q, bit_d;
  // Bits 6..0 of the byte still to be sent; bit 7 goes straight onto mosi at accept.
  logic [6:0] tx_q, tx_d;
  logic [7:0] rx_q, rx_d;
  logic       hold_q, hold_d;
  logic       sclk_q, sclk_d;
  logic       ss_q, ss_d;
  logic       mosi_q, mosi_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       phase_end;

  assign phase_end = (div_q == DivLast);

  // Next-state and registered-output logic for the transfer sequencer.
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    bit_d     = bit_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    hold_d    = hold_q;
    sclk_d    = sclk_q;
    ss_d      = ss_q;
    mosi_d    = mosi_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    rx_data_d = rx_data_q;

    // Divider runs in every non-idle phase and wraps at the end of each phase.
    if (state_q == StIdle) begin
      div_d = 8'd0;
    end else if (phase_end) begin
      div_d = 8'd0;
    end else begin
      div_d = div_q + 8'd1;
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          tx_d    = tx_data[6:0];
          hold_d  = hold_ss;
          ss_d    = 1'b0;
          mosi_d  = tx_data[7];
          busy_d  = 1'b1;
          bit_d   = 3'd0;
          state_d = StSetup;
        end
      end
      StSetup: begin
        if (phase_end) begin
          rx_d    = {rx_q[6:0], miso};
          sclk_d  = 1'b1;
          state_d = StHigh;
        end
      end
      StHigh: begin
        if (phase_end) begin
          sclk_d = 1'b0;
          if (bit_q != 3'd7) begin
            mosi_d  = tx_q[6];
            tx_d    = {tx_q[5:0], 1'b0};
            state_d = StLow;
          end else begin
            state_d = StFinish;
          end
        end
      end
      StLow: begin
        if (phase_end) begin
          rx_d    = {rx_q[6:0], miso};
          sclk_d  = 1'b1;
          bit_d   = bit_q + 3'd1;
          state_d = StHigh;
        end
      end
      StFinish: begin
        // One extra half-period of sclk low gives the slave hold time on the last bit.
        if (phase_end) begin
          rx_data_d = rx_q;
          done_d    = 1'b1;
          if (hold_q) begin
            busy_d  = 1'b0;
            state_d = StIdle;
          end else begin
            ss_d    = 1'b1;
            mosi_d  = 1'b0;
            state_d = StDesel;
          end
        end
      end
      StDesel: begin
        // Minimum deselect time before the next transfer may start.
        if (phase_end) begin
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers; asynchronous reset drops the bus to idle at once.
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state_q   <= StIdle;
      div_q     <= 8'd0;
      bit_q     <= 3'd0;
      tx_q      <= 7'd0;
      rx_q      <= 8'd0;
      hold_q    <= 1'b0;
      sclk_q    <= 1'b0;
      ss_q      <= 1'b1;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rx_data_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      hold_q    <= hold_d;
      sclk_q    <= sclk_d;
      ss_q      <= ss_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rx_data_q <= rx_data_d;
    end
  end

  assign sclk    = sclk_q;
  assign ss      = ss_q;
  assign mosi    = mosi_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign rx_data = rx_data_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: single byte, held-ss burst, ignored starts,
// mid-transfer reset. A clocked slave model shifts mosi in and drives miso with a
// deliberate glitch just after every rising sclk.
module tb_spi_master;

  localparam int unsigned D = 4;

  logic       clk = 1'b0;
  logic       rst_L;
  logic       start;
  logic [7:0] tx_data;
  logic       hold_ss;
  logic       busy;
  logic       done;
  logic [7:0] rx_data;
  logic       sclk;
  logic       ss;
  logic       mosi;
  logic       miso = 1'b0;

  always #5 clk = ~clk;

  spi_master #(.CLK_DIV(D)) dut (
    .clk     (clk),
    .rst_L   (rst_L),
    .start   (start),
    .tx_data (tx_data),
    .hold_ss (hold_ss),
    .busy    (busy),
    .done    (done),
    .rx_data (rx_data),
    .sclk    (sclk),
    .ss      (ss),
    .mosi    (mosi),
    .miso    (miso)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, act, exp);
    end
  endtask

  // Free-running cycle count; a transfer's cycle k is cyc - t0 at the negedge.
  int cyc = 0;
  int t0  = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave model. Sees DUT outputs one clk after they change; miso is driven
  // inverted for the first half-period after each rising sclk, then corrected.
  logic [7:0] slv_load [0:1];
  logic [7:0] slv_got  [0:15];
  int         slv_n    = 0;
  logic       s_ss_p   = 1'b1;
  logic       s_sclk_p = 1'b0;
  logic [7:0] s_cur    = 8'h00;
  logic [7:0] s_rx     = 8'h00;
  logic       s_val    = 1'b0;
  int         s_cnt    = 0;
  int         s_idx    = 0;
  int         s_gl     = 0;

  always @(posedge clk) begin
    logic [7:0] nrx;
    logic [7:0] ncur;
    logic       nbit;
    int         cnt1;
    s_ss_p   <= ss;
    s_sclk_p <= sclk;
    if (s_gl > 0) begin
      s_gl <= s_gl - 1;
      if (s_gl == 1) miso <= s_val;
    end
    if (s_ss_p && !ss) begin
      s_cur <= slv_load[0];
      s_idx <= 0;
      s_cnt <= 0;
      miso  <= slv_load[0][7];
    end else if (!s_ss_p && ss) begin
      s_cnt <= 0;
    end else if (!ss && sclk && !s_sclk_p) begin
      nrx  = {s_rx[6:0], mosi};
      cnt1 = s_cnt + 1;
      s_rx <= nrx;
      if (cnt1 == 8) begin
        if (slv_n < 16) slv_got[slv_n] <= nrx;
        slv_n <= slv_n + 1;
        s_cnt <= 0;
        ncur  = slv_load[(s_idx + 1) % 2];
        s_idx <= s_idx + 1;
        s_cur <= ncur;
        nbit  = ncur[7];
      end else begin
        s_cnt <= cnt1;
        nbit  = s_cur[7 - cnt1];
      end
      miso  <= ~nbit;
      s_val <= nbit;
      s_gl  <= D - 1;
    end
  end

  // Bus monitor: timestamps edges and done pulses at every negedge.
  logic       m_sclk_p  = 1'b0;
  logic       m_ss_p    = 1'b1;
  logic       m_busy_p  = 1'b0;
  int         n_rise    = 0;
  int         rise_cyc [0:63];
  int         last_fall = 0;
  int         n_done    = 0;
  int         done_cyc [0:15];
  logic [7:0] done_rx  [0:15];
  int         ss_fall_cyc = 0;
  int         ss_rise_cyc = 0;
  int         n_ss_rise   = 0;
  int         busy_fall_cyc = 0;
  int         low_run   = 0;
  int         busy_gap  = -1;
  int         viol      = 0;

  always @(negedge clk) begin
    m_sclk_p <= sclk;
    m_ss_p   <= ss;
    m_busy_p <= busy;
    if (sclk && !m_sclk_p) begin
      if (n_rise < 64) rise_cyc[n_rise] <= cyc;
      n_rise <= n_rise + 1;
    end
    if (!sclk && m_sclk_p) last_fall <= cyc;
    if (done && n_done < 16) begin
      done_cyc[n_done] <= cyc;
      done_rx[n_done]  <= rx_data;
    end
    if (done) n_done <= n_done + 1;
    if (!ss && m_ss_p) ss_fall_cyc <= cyc;
    if (ss && !m_ss_p) begin
      ss_rise_cyc <= cyc;
      n_ss_rise   <= n_ss_rise + 1;
    end
    if (!busy && m_busy_p) busy_fall_cyc <= cyc;
    if (!busy) begin
      low_run <= low_run + 1;
    end else begin
      if (!m_busy_p) busy_gap <= low_run;
      low_run <= 0;
    end
    if (sclk && ss) viol <= viol + 1;
  end

  // Called at a negedge with busy low; returns at the negedge of cycle 1.
  task automatic start_xfer(input logic [7:0] d, input logic h);
    t0      = cyc;
    start   = 1'b1;
    tx_data = d;
    hold_ss = h;
    @(negedge clk);
    start   = 1'b0;
    tx_data = ~d;
    hold_ss = ~h;
  endtask

  // Returns at the first negedge where busy reads 0, or flags a timeout.
  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, 32'(busy), 0);
  endtask

  task automatic wait_rel(input int target);
    while (cyc - t0 < target) @(negedge clk);
  endtask

  int r0, d0, sl0, ssr0, ta, tb;

  initial begin
    rst_L   = 1'b0;
    start   = 1'b0;
    tx_data = 8'h00;
    hold_ss = 1'b0;
    slv_load[0] = 8'h00;
    slv_load[1] = 8'h00;
    repeat (3) @(negedge clk);
    check_eq("rst_sclk", 32'(sclk), 0);
    check_eq("rst_ss", 32'(ss), 1);
    check_eq("rst_mosi", 32'(mosi), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_done", 32'(done), 0);
    check_eq("rst_rx", 32'(rx_data), 0);
    rst_L = 1'b1;
    repeat (2) @(negedge clk);

    // Single byte A5 out, 3C back; inputs scrambled after acceptance.
    slv_load[0] = 8'h3C;
    r0 = n_rise; d0 = n_done; sl0 = slv_n;
    start_xfer(8'hA5, 1'b0);
    check_eq("a_busy_c1", 32'(busy), 1);
    wait_idle("a_idle");
    @(negedge clk);
    check_eq("a_ss_fall", ss_fall_cyc - t0, 1);
    check_eq("a_nrise", n_rise - r0, 8);
    for (int k = 0; k < 8; k++) begin
      check_eq($sformatf("a_rise%0d", k), rise_cyc[r0 + k] - t0, 1 + D * (1 + 2 * k));
    end
    check_eq("a_last_fall", last_fall - t0, 1 + 16 * D);
    check_eq("a_ndone", n_done - d0, 1);
    check_eq("a_done_cyc", done_cyc[d0] - t0, 1 + 17 * D);
    check_eq("a_done_rx", 32'(done_rx[d0]), 'h3C);
    check_eq("a_rx_hold", 32'(rx_data), 'h3C);
    check_eq("a_slave_got", 32'(slv_got[sl0]), 'hA5);
    check_eq("a_ss_rise", ss_rise_cyc - t0, 1 + 17 * D);
    check_eq("a_busy_fall", busy_fall_cyc - t0, 1 + 18 * D);
    check_eq("a_mosi_idle", 32'(mosi), 0);
    check_eq("a_ss_idle", 32'(ss), 1);

    // Burst: 01 with hold_ss, then FF started on the first busy-low cycle.
    slv_load[0] = 8'h96;
    slv_load[1] = 8'h69;
    r0 = n_rise; d0 = n_done; sl0 = slv_n; ssr0 = n_ss_rise;
    start_xfer(8'h01, 1'b1);
    ta = t0;
    wait_idle("b1_idle");
    check_eq("b1_idle_cyc", cyc - ta, 1 + 17 * D);
    check_eq("b1_ss_held", 32'(ss), 0);
    check_eq("b1_mosi_hold", 32'(mosi), 1);
    start_xfer(8'hFF, 1'b0);
    tb = t0;
    wait_idle("b2_idle");
    @(negedge clk);
    check_eq("b_nrise", n_rise - r0, 16);
    check_eq("b_ndone", n_done - d0, 2);
    check_eq("b_rx0", 32'(done_rx[d0]), 'h96);
    check_eq("b_rx1", 32'(done_rx[d0 + 1]), 'h69);
    check_eq("b_slave0", 32'(slv_got[sl0]), 'h01);
    check_eq("b_slave1", 32'(slv_got[sl0 + 1]), 'hFF);
    check_eq("b_ss_rises", n_ss_rise - ssr0, 1);
    check_eq("b_ss_rise_cyc", ss_rise_cyc - tb, 1 + 17 * D);
    check_eq("b_busy_gap", busy_gap, 1);
    check_eq("b2_first_rise", rise_cyc[r0 + 8] - tb, 1 + D);
    check_eq("b2_done_cyc", done_cyc[d0 + 1] - tb, 1 + 17 * D);

    // Start pulses while busy are dropped.
    slv_load[0] = 8'hC3;
    r0 = n_rise; d0 = n_done; sl0 = slv_n;
    start_xfer(8'h3A, 1'b0);
    wait_rel(10);
    start = 1'b1; tx_data = 8'hFF; hold_ss = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_rel(10 * D);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle("c_idle");
    repeat (3) @(negedge clk);
    check_eq("c_still_idle", 32'(busy), 0);
    check_eq("c_ndone", n_done - d0, 1);
    check_eq("c_nrise", n_rise - r0, 8);
    check_eq("c_rx", 32'(done_rx[d0]), 'hC3);
    check_eq("c_slave_got", 32'(slv_got[sl0]), 'h3A);

    // Reset mid-byte, then a clean 5A transfer.
    slv_load[0] = 8'h11;
    d0 = n_done;
    start_xfer(8'h77, 1'b0);
    wait_rel(30);
    rst_L = 1'b0;
    #1;
    check_eq("d_rst_sclk", 32'(sclk), 0);
    check_eq("d_rst_ss", 32'(ss), 1);
    check_eq("d_rst_busy", 32'(busy), 0);
    check_eq("d_rst_mosi", 32'(mosi), 0);
    check_eq("d_rst_rx", 32'(rx_data), 0);
    repeat (2) @(negedge clk);
    rst_L = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("d_no_done", n_done - d0, 0);
    slv_load[0] = 8'hE7;
    d0 = n_done; sl0 = slv_n; r0 = n_rise;
    start_xfer(8'h5A, 1'b0);
    wait_idle("d_idle");
    @(negedge clk);
    check_eq("d_ndone", n_done - d0, 1);
    check_eq("d_nrise", n_rise - r0, 8);
    check_eq("d_rx", 32'(rx_data), 'hE7);
    check_eq("d_slave_got", 32'(slv_got[sl0]), 'h5A);
    check_eq("d_done_cyc", done_cyc[d0] - t0, 1 + 17 * D);
    check_eq("sclk_high_while_deselected", viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
